// File: rtl/dmu_sio_pkg.sv
// Shared types and helpers for the SIU->DMU receive path.
package dmu_sio_pkg;

    localparam int unsigned DW    = 128;
    localparam int unsigned PW    = 8;
    localparam int unsigned BEATS = 4;
    localparam int unsigned SW    = DW / PW;
    localparam int unsigned BCW   = $clog2(BEATS);

    typedef enum logic [0:0] {StIdle, StPay} state_e;

    typedef struct packed {
        logic [DW-1:0]       hdr;
        logic                has_pay;
        logic [DW*BEATS-1:0] pay;
        logic [BEATS-1:0]    par_err;
    } pkt_t;

    // Even parity per SW-bit slice; any mismatching slice flags the beat.
    function automatic logic slice_par_err(input logic [DW-1:0] data,
                                           input logic [PW-1:0] parity);
        logic err;
        err = 1'b0;
        for (int i = 0; i < int'(PW); i++) begin
            err = err | ((^data[i*SW +: SW]) ^ parity[i]);
        end
        return err;
    endfunction

endpackage

// File: rtl/dmu_sio_rx_fifo.sv
// Depth-entry synchronous FIFO of received packets; head output is zero when empty.
module dmu_sio_rx_fifo
    import dmu_sio_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  pkt_t wdata_i,
    input  logic pop_i,
    output pkt_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    pkt_t            mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= next_ptr(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= next_ptr(rptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmu_sio_rx.sv
// SIU->DMU receive endpoint: header/payload assembly, beat parity check,
// packet buffer with valid/ready head and per-pop credit return.
module dmu_sio_rx #(
    parameter int unsigned DW    = 128,
    parameter int unsigned PW    = 8,
    parameter int unsigned BEATS = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                iol2clk,
    input  logic                rst_l,
    input  logic                sio_dmu_hdr_vld,
    input  logic                sio_dmu_datareq,
    input  logic [DW-1:0]       sio_dmu_data,
    input  logic [PW-1:0]       sio_dmu_parity,
    output logic                rx_vld,
    input  logic                rx_rdy,
    output logic [DW-1:0]       rx_hdr,
    output logic                rx_has_pay,
    output logic [DW*BEATS-1:0] rx_pay,
    output logic [BEATS-1:0]    rx_par_err,
    output logic                dmu_sio_credit,
    output logic                err_ovf,
    output logic                err_proto
);

    import dmu_sio_pkg::*;

    state_e              state_q, state_d;
    logic [BCW-1:0]      beat_q, beat_d;
    logic [DW-1:0]       hdr_q, hdr_d;
    logic [DW*BEATS-1:0] pay_q, pay_d;
    logic [BEATS-1:0]    perr_q, perr_d;
    logic                commit, proto_d;
    pkt_t                commit_pkt, head;
    logic                full, empty, pop, push;
    logic                credit_q, ovf_q, proto_q;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        hdr_d      = hdr_q;
        pay_d      = pay_q;
        perr_d     = perr_q;
        commit     = 1'b0;
        commit_pkt = '0;
        proto_d    = 1'b0;
        // A header always wins: in StPay it abandons the partial packet.
        if (sio_dmu_hdr_vld) begin
            proto_d = (state_q == StPay);
            if (sio_dmu_datareq) begin
                state_d = StPay;
                beat_d  = '0;
                hdr_d   = sio_dmu_data;
            end else begin
                state_d        = StIdle;
                commit         = 1'b1;
                commit_pkt.hdr = sio_dmu_data;
            end
        end else if (state_q == StPay) begin
            pay_d[int'(beat_q)*DW +: DW] = sio_dmu_data;
            perr_d[beat_q]               = slice_par_err(sio_dmu_data, sio_dmu_parity);
            beat_d                       = beat_q + 1'b1;
            if (beat_q == BCW'(BEATS - 1)) begin
                state_d            = StIdle;
                beat_d             = '0;
                commit             = 1'b1;
                commit_pkt.hdr     = hdr_q;
                commit_pkt.has_pay = 1'b1;
                commit_pkt.pay     = pay_d;
                commit_pkt.par_err = perr_d;
            end
        end
    end

    assign pop  = !empty && rx_rdy;
    assign push = commit && (!full || pop);

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            hdr_q    <= '0;
            pay_q    <= '0;
            perr_q   <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            hdr_q    <= hdr_d;
            pay_q    <= pay_d;
            perr_q   <= perr_d;
            credit_q <= pop;
            ovf_q    <= commit && full && !pop;
            proto_q  <= proto_d;
        end
    end

    dmu_sio_rx_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (iol2clk),
        .rst_ni  (rst_l),
        .push_i  (push),
        .wdata_i (commit_pkt),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign rx_vld         = !empty;
    assign rx_hdr         = head.hdr;
    assign rx_has_pay     = head.has_pay;
    assign rx_pay         = head.pay;
    assign rx_par_err     = head.par_err;
    assign dmu_sio_credit = credit_q;
    assign err_ovf        = ovf_q;
    assign err_proto      = proto_q;

endmodule

// File: tb/tb_dmu_sio_rx.sv
// Directed bench for dmu_sio_rx: expected packets are queued at stimulus time and
// checked by a monitor whenever the head is accepted.
module tb_dmu_sio_rx;

    import dmu_sio_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic                iol2clk = 1'b0;
    logic                rst_l;
    logic                sio_dmu_hdr_vld;
    logic                sio_dmu_datareq;
    logic [DW-1:0]       sio_dmu_data;
    logic [PW-1:0]       sio_dmu_parity;
    logic                rx_vld;
    logic                rx_rdy;
    logic [DW-1:0]       rx_hdr;
    logic                rx_has_pay;
    logic [DW*BEATS-1:0] rx_pay;
    logic [BEATS-1:0]    rx_par_err;
    logic                dmu_sio_credit;
    logic                err_ovf;
    logic                err_proto;

    int   n_tests = 0;
    int   n_fail  = 0;
    pkt_t exp_q[$];
    logic pop_prev = 1'b0;

    localparam logic [DW-1:0] HA5 = {16{8'hA5}};

    always #5 iol2clk = ~iol2clk;

    dmu_sio_rx #(
        .DW    (DW),
        .PW    (PW),
        .BEATS (BEATS),
        .DEPTH (DEPTH)
    ) dut (
        .iol2clk         (iol2clk),
        .rst_l           (rst_l),
        .sio_dmu_hdr_vld (sio_dmu_hdr_vld),
        .sio_dmu_datareq (sio_dmu_datareq),
        .sio_dmu_data    (sio_dmu_data),
        .sio_dmu_parity  (sio_dmu_parity),
        .rx_vld          (rx_vld),
        .rx_rdy          (rx_rdy),
        .rx_hdr          (rx_hdr),
        .rx_has_pay      (rx_has_pay),
        .rx_pay          (rx_pay),
        .rx_par_err      (rx_par_err),
        .dmu_sio_credit  (dmu_sio_credit),
        .err_ovf         (err_ovf),
        .err_proto       (err_proto)
    );

    task automatic check(input string name, input logic [DW*BEATS-1:0] act,
                         input logic [DW*BEATS-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic pkt_t mk(input logic [DW-1:0] h, input logic hp,
                                input logic [DW*BEATS-1:0] p, input logic [BEATS-1:0] pe);
        pkt_t r;
        r.hdr     = h;
        r.has_pay = hp;
        r.pay     = p;
        r.par_err = pe;
        return r;
    endfunction

    task automatic tick();
        @(posedge iol2clk);
        #1;
    endtask

    task automatic send_hdr(input logic [DW-1:0] h, input logic req);
        sio_dmu_hdr_vld = 1'b1;
        sio_dmu_datareq = req;
        sio_dmu_data    = h;
        sio_dmu_parity  = '0;
        tick();
        sio_dmu_hdr_vld = 1'b0;
        sio_dmu_datareq = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [PW-1:0] p);
        sio_dmu_data   = d;
        sio_dmu_parity = p;
        tick();
    endtask

    // Scoreboard monitor: compares the head on every accepted pop and the credit pulse.
    always @(negedge iol2clk) begin
        pkt_t e;
        if (!rst_l) begin
            pop_prev = 1'b0;
        end else begin
            check("credit", dmu_sio_credit, pop_prev);
            if (rx_vld && rx_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pkt: got hdr %0h, expected none", rx_hdr);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_hdr", rx_hdr, e.hdr);
                    check("sb_has_pay", rx_has_pay, e.has_pay);
                    check("sb_pay", rx_pay, e.pay);
                    check("sb_par_err", rx_par_err, e.par_err);
                end
            end
            pop_prev = rx_vld && rx_rdy;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l           = 1'b0;
        sio_dmu_hdr_vld = 1'b0;
        sio_dmu_datareq = 1'b0;
        sio_dmu_data    = '0;
        sio_dmu_parity  = '0;
        rx_rdy          = 1'b0;
        #12;
        check("rst_vld", rx_vld, 1'b0);
        check("rst_hdr", rx_hdr, '0);
        check("rst_pay", rx_pay, '0);
        check("rst_has_pay", rx_has_pay, 1'b0);
        check("rst_par_err", rx_par_err, '0);
        check("rst_pulses", {dmu_sio_credit, err_ovf, err_proto}, 3'b000);
        tick();
        rst_l = 1'b1;
        tick();

        // Header-only packet, then pop -> credit.
        exp_q.push_back(mk(HA5, 1'b0, '0, '0));
        send_hdr(HA5, 1'b0);
        check("ho_vld", rx_vld, 1'b1);
        check("ho_hdr", rx_hdr, HA5);
        check("ho_has_pay", rx_has_pay, 1'b0);
        rx_rdy = 1'b1;
        tick();
        check("ho_credit", dmu_sio_credit, 1'b1);
        check("ho_vld_after_pop", rx_vld, 1'b0);
        rx_rdy = 1'b0;
        tick();
        check("ho_credit_width", dmu_sio_credit, 1'b0);

        // Payload packet with clean parity, then back-to-back one with a bad slice on beat 2.
        exp_q.push_back(mk(128'h11, 1'b1, {128'h4, 128'h3, 128'h2, 128'h1}, 4'b0000));
        exp_q.push_back(mk(128'h22, 1'b1, {128'h8, 128'h7, 128'h6, 128'h5}, 4'b0100));
        send_hdr(128'h11, 1'b1);
        send_beat(128'h1, 8'h01);
        send_beat(128'h2, 8'h01);
        send_beat(128'h3, 8'h00);
        check("pay_vld_early", rx_vld, 1'b0);
        send_beat(128'h4, 8'h01);
        check("pay_vld", rx_vld, 1'b1);
        check("pay_data", rx_pay, {128'h4, 128'h3, 128'h2, 128'h1});
        send_hdr(128'h22, 1'b1);
        send_beat(128'h5, 8'h00);
        send_beat(128'h6, 8'h00);
        send_beat(128'h7, 8'h08);
        send_beat(128'h8, 8'h01);
        check("b2b_head_stable", rx_hdr, 128'h11);
        rx_rdy = 1'b1;
        tick();
        check("perr_head", rx_par_err, 4'b0100);
        tick();
        rx_rdy = 1'b0;
        check("b2b_drained", rx_vld, 1'b0);

        // Overflow: third packet into a full buffer is dropped.
        exp_q.push_back(mk(128'h33, 1'b0, '0, '0));
        exp_q.push_back(mk(128'h44, 1'b0, '0, '0));
        send_hdr(128'h33, 1'b0);
        send_hdr(128'h44, 1'b0);
        check("ovf_none_yet", err_ovf, 1'b0);
        send_hdr(128'h55, 1'b0);
        check("ovf_pulse", err_ovf, 1'b1);
        check("ovf_no_credit", dmu_sio_credit, 1'b0);
        tick();
        check("ovf_width", err_ovf, 1'b0);
        rx_rdy = 1'b1;
        tick();
        tick();
        rx_rdy = 1'b0;
        check("ovf_drained", rx_vld, 1'b0);

        // Full buffer with a pop on the commit edge: no drop.
        exp_q.push_back(mk(128'h66, 1'b0, '0, '0));
        exp_q.push_back(mk(128'h77, 1'b0, '0, '0));
        exp_q.push_back(mk(128'h88, 1'b0, '0, '0));
        send_hdr(128'h66, 1'b0);
        send_hdr(128'h77, 1'b0);
        rx_rdy = 1'b1;
        send_hdr(128'h88, 1'b0);
        check("ovf_pop_none", err_ovf, 1'b0);
        check("ovf_pop_head", rx_hdr, 128'h77);
        tick();
        tick();
        rx_rdy = 1'b0;
        check("ovf_pop_drained", rx_vld, 1'b0);

        // Protocol abort: header mid-payload replaces the partial packet.
        exp_q.push_back(mk(128'hBB, 1'b0, '0, '0));
        send_hdr(128'hAA, 1'b1);
        send_beat(128'h9, 8'h00);
        send_beat(128'hA, 8'h00);
        send_hdr(128'hBB, 1'b0);
        check("proto_pulse", err_proto, 1'b1);
        check("proto_hdr", rx_hdr, 128'hBB);
        tick();
        check("proto_width", err_proto, 1'b0);
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        check("proto_drained", rx_vld, 1'b0);

        // Reset mid-payload with a packet already buffered; that packet is lost.
        send_hdr(128'hCC, 1'b0);
        send_hdr(128'hDD, 1'b1);
        send_beat(128'hB, 8'h00);
        send_beat(128'hC, 8'h00);
        #2;
        rst_l = 1'b0;
        #1;
        check("mrst_vld", rx_vld, 1'b0);
        check("mrst_hdr", rx_hdr, '0);
        check("mrst_pay", rx_pay, '0);
        check("mrst_flags", {rx_has_pay, rx_par_err, dmu_sio_credit, err_ovf, err_proto}, '0);
        tick();
        rst_l = 1'b1;
        exp_q.push_back(mk(128'hEE, 1'b0, '0, '0));
        send_hdr(128'hEE, 1'b0);
        check("mrst_idle_vld", rx_vld, 1'b1);
        check("mrst_idle_hdr", rx_hdr, 128'hEE);
        check("mrst_no_proto", err_proto, 1'b0);
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        tick();

        check("sb_all_delivered", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
